// File: rtl/rd_ctrl_pkg.sv
// Shared definitions for the counter read-back controller: bus address codes,
// read/write byte-mode codes, the read-back selector and the control-word layout.
package rd_ctrl_pkg;

  localparam int CNT_W = 16;
  localparam int NUM_CNT = 3;

  // Bus address as {A0, A1}
  localparam logic [1:0] ADDR_CNT0 = 2'b00;
  localparam logic [1:0] ADDR_CNT1 = 2'b01;
  localparam logic [1:0] ADDR_CNT2 = 2'b10;
  localparam logic [1:0] ADDR_CTRL = 2'b11;

  // Select-counter field value that turns a control write into a read-back command
  localparam logic [1:0] SC_READBACK = 2'b11;

  // Byte access mode; RW_NONE doubles as the counter-latch command code
  typedef enum logic [1:0] {
    RW_NONE    = 2'b00,
    RW_LSB     = 2'b01,
    RW_MSB     = 2'b10,
    RW_LSB_MSB = 2'b11
  } rw_mode_e;

  // Control word layout. For read-back, rw[1]=0 latches count, rw[0]=0 latches
  // status, and rb_sel[n] selects counter n.
  typedef struct packed {
    logic [1:0] sc;
    logic [1:0] rw;
    logic [2:0] rb_sel;
    logic       rsvd;
  } ctrl_word_t;

  function automatic logic [7:0] pick_byte(input logic [CNT_W-1:0] value, input logic hi);
    return hi ? value[CNT_W-1:8] : value[7:0];
  endfunction

endpackage

// File: rtl/rd_ctrl_latch.sv
// Per-counter read state: byte mode, count latch, status latch and byte pointer.
// rd_data is the byte a read issued this cycle would return (pre-cycle state).
module rd_latch
  import rd_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_en,
  input  logic             mode_wr,
  input  logic [1:0]       mode_new,
  input  logic             cnt_latch,
  input  logic             sts_latch,
  input  logic [CNT_W-1:0] count,
  input  logic [7:0]       status,
  output logic [7:0]       rd_data
);

  rw_mode_e         rw_mode_q, rw_mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_full_q, cnt_full_d;
  logic [7:0]       sts_q, sts_d;
  logic             sts_full_q, sts_full_d;
  logic             ptr_msb_q, ptr_msb_d;

  logic             hi_byte;
  logic             read_completes;
  logic [CNT_W-1:0] cnt_src;

  // Byte selection and read data from the current (pre-cycle) state
  always_comb begin
    hi_byte        = (rw_mode_q == RW_MSB) || ((rw_mode_q == RW_LSB_MSB) && ptr_msb_q);
    read_completes = (rw_mode_q != RW_LSB_MSB) || ptr_msb_q;
    cnt_src        = cnt_full_q ? cnt_q : count;
    rd_data        = sts_full_q ? sts_q : pick_byte(cnt_src, hi_byte);
  end

  // Next state: read-side effects first, then commands so a fresh latch wins
  always_comb begin
    rw_mode_d  = rw_mode_q;
    cnt_d      = cnt_q;
    cnt_full_d = cnt_full_q;
    sts_d      = sts_q;
    sts_full_d = sts_full_q;
    ptr_msb_d  = ptr_msb_q;

    if (rd_en) begin
      if (sts_full_q) begin
        // status read leaves the byte pointer where it was
        sts_full_d = 1'b0;
      end else begin
        if (cnt_full_q && read_completes) begin
          cnt_full_d = 1'b0;
        end
        if (rw_mode_q == RW_LSB_MSB) begin
          ptr_msb_d = ~ptr_msb_q;
        end
      end
    end

    if (mode_wr) begin
      rw_mode_d  = rw_mode_e'(mode_new);
      cnt_full_d = 1'b0;
      sts_full_d = 1'b0;
      ptr_msb_d  = 1'b0;
    end else begin
      // the pointer is deliberately untouched so a latch between LSB and MSB
      // reads of the live count still yields the MSB next
      if (cnt_latch && !cnt_full_d) begin
        cnt_d      = count;
        cnt_full_d = 1'b1;
      end
      if (sts_latch && !sts_full_d) begin
        sts_d      = status;
        sts_full_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_mode_q  <= RW_NONE;
      cnt_q      <= '0;
      cnt_full_q <= 1'b0;
      sts_q      <= '0;
      sts_full_q <= 1'b0;
      ptr_msb_q  <= 1'b0;
    end else begin
      rw_mode_q  <= rw_mode_d;
      cnt_q      <= cnt_d;
      cnt_full_q <= cnt_full_d;
      sts_q      <= sts_d;
      sts_full_q <= sts_full_d;
      ptr_msb_q  <= ptr_msb_d;
    end
  end

endmodule

// File: rtl/rd_ctrl.sv
// Counter read-back controller: decodes control words and bus reads, routes
// them to three per-counter latch blocks and registers the read byte.
module rd_ctrl
  import rd_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CS,
  input  logic             A0,
  input  logic             A1,
  input  logic             rd,
  input  logic             ctrl_wr,
  input  logic [7:0]       ctrl_data,
  input  logic [CNT_W-1:0] count0,
  input  logic [CNT_W-1:0] count1,
  input  logic [CNT_W-1:0] count2,
  input  logic [7:0]       status0,
  input  logic [7:0]       status1,
  input  logic [7:0]       status2,
  output logic [7:0]       dout,
  output logic             dout_valid
);

  logic [1:0]       addr;
  logic             rd_hit;
  logic             is_readback;
  ctrl_word_t       cw;
  logic             unused_rsvd;

  logic [NUM_CNT-1:0] rd_en;
  logic [NUM_CNT-1:0] mode_wr;
  logic [NUM_CNT-1:0] cnt_latch;
  logic [NUM_CNT-1:0] sts_latch;

  logic [CNT_W-1:0] count_arr   [NUM_CNT];
  logic [7:0]       status_arr  [NUM_CNT];
  logic [7:0]       rd_data_arr [NUM_CNT];
  logic [7:0]       rd_byte;

  assign addr        = {A0, A1};
  assign rd_hit      = rd & CS;
  assign cw          = ctrl_data;
  assign is_readback = ctrl_wr && (cw.sc == SC_READBACK);
  assign unused_rsvd = cw.rsvd;

  assign count_arr[0]  = count0;
  assign count_arr[1]  = count1;
  assign count_arr[2]  = count2;
  assign status_arr[0] = status0;
  assign status_arr[1] = status1;
  assign status_arr[2] = status2;

  // Per-counter strobes from the bus read and the control word
  always_comb begin
    rd_en     = '0;
    mode_wr   = '0;
    cnt_latch = '0;
    sts_latch = '0;
    for (int n = 0; n < NUM_CNT; n++) begin
      rd_en[n]     = rd_hit && (addr == 2'(n));
      mode_wr[n]   = ctrl_wr && (cw.sc == 2'(n)) && (cw.rw != RW_NONE);
      cnt_latch[n] = (ctrl_wr && (cw.sc == 2'(n)) && (cw.rw == RW_NONE)) ||
                     (is_readback && cw.rb_sel[n] && !cw.rw[1]);
      sts_latch[n] = is_readback && cw.rb_sel[n] && !cw.rw[0];
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    rd_latch u_latch (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_en     (rd_en[g]),
      .mode_wr   (mode_wr[g]),
      .mode_new  (cw.rw),
      .cnt_latch (cnt_latch[g]),
      .sts_latch (sts_latch[g]),
      .count     (count_arr[g]),
      .status    (status_arr[g]),
      .rd_data   (rd_data_arr[g])
    );
  end

  // Read data mux; the control address always reads as zero
  always_comb begin
    rd_byte = 8'h00;
    case (addr)
      ADDR_CNT0: rd_byte = rd_data_arr[0];
      ADDR_CNT1: rd_byte = rd_data_arr[1];
      ADDR_CNT2: rd_byte = rd_data_arr[2];
      ADDR_CTRL: rd_byte = 8'h00;
      default:   rd_byte = 8'h00;
    endcase
  end

  // Output register: one-cycle latency, dout holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= 8'h00;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_hit;
      if (rd_hit) begin
        dout <= rd_byte;
      end
    end
  end

endmodule

// File: tb/tb_rd_ctrl.sv
// Bench for rd_ctrl: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a byte-queue reference model.
module tb_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        CS = 1'b0;
  logic        A0 = 1'b0;
  logic        A1 = 1'b0;
  logic        rd = 1'b0;
  logic        ctrl_wr = 1'b0;
  logic [7:0]  ctrl_data = 8'h00;
  logic [15:0] count0 = 16'h0, count1 = 16'h0, count2 = 16'h0;
  logic [7:0]  status0 = 8'h0, status1 = 8'h0, status2 = 8'h0;
  logic [7:0]  dout;
  logic        dout_valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rd_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .CS         (CS),
    .A0         (A0),
    .A1         (A1),
    .rd         (rd),
    .ctrl_wr    (ctrl_wr),
    .ctrl_data  (ctrl_data),
    .count0     (count0),
    .count1     (count1),
    .count2     (count2),
    .status0    (status0),
    .status1    (status1),
    .status2    (status2),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  // ---------------- reference model ----------------
  // A latched count is kept as the list of bytes still owed to the reader;
  // the latch is empty when that list is exhausted.
  int         m_mode [3];
  bit         m_ptr  [3];
  logic [7:0] m_cb   [3][2];
  int         m_cl   [3];
  logic [7:0] m_sb   [3];
  bit         m_sv   [3];
  logic [7:0] exp_dout;
  bit         exp_valid;
  logic [7:0] m_b;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] live_count(input int n);
    case (n)
      0:       return count0;
      1:       return count1;
      default: return count2;
    endcase
  endfunction

  function automatic logic [7:0] live_status(input int n);
    case (n)
      0:       return status0;
      1:       return status1;
      default: return status2;
    endcase
  endfunction

  task automatic m_reset();
    for (int n = 0; n < 3; n++) begin
      m_mode[n] = 0;
      m_ptr[n]  = 1'b0;
      m_cl[n]   = 0;
      m_sv[n]   = 1'b0;
    end
    exp_valid = 1'b0;
    exp_dout  = 8'h00;
  endtask

  task automatic m_latch_count(input int n);
    logic [15:0] v;
    v = live_count(n);
    if (m_mode[n] == 2) begin
      m_cb[n][0] = v[15:8]; m_cl[n] = 1;
    end else if (m_mode[n] == 3 && !m_ptr[n]) begin
      m_cb[n][0] = v[7:0]; m_cb[n][1] = v[15:8]; m_cl[n] = 2;
    end else if (m_mode[n] == 3) begin
      m_cb[n][0] = v[15:8]; m_cl[n] = 1;
    end else begin
      m_cb[n][0] = v[7:0]; m_cl[n] = 1;
    end
  endtask

  task automatic m_read(input int n, output logic [7:0] b);
    logic [15:0] v;
    if (m_sv[n]) begin
      b = m_sb[n];
      m_sv[n] = 1'b0;
    end else begin
      if (m_cl[n] > 0) begin
        b = m_cb[n][0];
        m_cb[n][0] = m_cb[n][1];
        m_cl[n]--;
      end else begin
        v = live_count(n);
        b = (m_mode[n] == 2 || (m_mode[n] == 3 && m_ptr[n])) ? v[15:8] : v[7:0];
      end
      if (m_mode[n] == 3) m_ptr[n] = !m_ptr[n];
    end
  endtask

  task automatic m_cmd(input logic [7:0] d);
    int sc, rw;
    sc = int'(d[7:6]);
    rw = int'(d[5:4]);
    if (sc != 3) begin
      if (rw != 0) begin
        m_mode[sc] = rw; m_cl[sc] = 0; m_sv[sc] = 1'b0; m_ptr[sc] = 1'b0;
      end else if (m_cl[sc] == 0) begin
        m_latch_count(sc);
      end
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (d[n+1]) begin
          if (!d[5] && m_cl[n] == 0) m_latch_count(n);
          if (!d[4] && !m_sv[n]) begin
            m_sb[n] = live_status(n);
            m_sv[n] = 1'b1;
          end
        end
      end
    end
  endtask

  // Model update on each active edge: read effects, then the control command
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset();
    end else begin
      exp_valid = 1'b0;
      if (rd && CS) begin
        exp_valid = 1'b1;
        if ({A0, A1} == 2'b11) begin
          exp_dout = 8'h00;
        end else begin
          m_read(int'({A0, A1}), m_b);
          exp_dout = m_b;
        end
      end
      if (ctrl_wr) m_cmd(ctrl_data);
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("valid", {15'h0, dout_valid}, {15'h0, exp_valid});
      if (exp_valid) check("dout", {8'h0, dout}, {8'h0, exp_dout});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl(input logic [7:0] d);
    ctrl_data = d;
    ctrl_wr   = 1'b1;
    cyc();
    ctrl_wr   = 1'b0;
  endtask

  task automatic rd_lit(input logic [1:0] addr, input logic [7:0] exp, input string name);
    {A0, A1} = addr;
    CS = 1'b1;
    rd = 1'b1;
    cyc();
    rd = 1'b0;
    CS = 1'b0;
    @(negedge clk);
    check(name, {8'h0, dout}, {8'h0, exp});
    check({name, "_vld"}, {15'h0, dout_valid}, 16'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_dout", {8'h0, dout}, 16'h0);
    check("rst_valid", {15'h0, dout_valid}, 16'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // counter0 LSB-then-MSB on the live count
    ctrl(8'h30);
    count0 = 16'hABCD;
    rd_lit(2'b00, 8'hCD, "live_lsb");
    rd_lit(2'b00, 8'hAB, "live_msb");
    cyc();
    @(negedge clk);
    check("valid_one_cycle", {15'h0, dout_valid}, 16'h0);

    // counter1 latch then live count moves
    ctrl(8'h70);
    count1 = 16'h1234;
    ctrl(8'h40);
    count1 = 16'h5555;
    rd_lit(2'b01, 8'h34, "latch_lsb");
    rd_lit(2'b01, 8'h12, "latch_msb");
    rd_lit(2'b01, 8'h55, "after_latch_live");

    // read-back of count and status on counter1
    ctrl(8'h70);
    count1  = 16'h7A3C;
    status1 = 8'h96;
    ctrl(8'hC4);
    count1  = 16'h0000;
    status1 = 8'h00;
    rd_lit(2'b01, 8'h96, "rb_status");
    rd_lit(2'b01, 8'h3C, "rb_cnt_lsb");
    rd_lit(2'b01, 8'h7A, "rb_cnt_msb");

    // second latch ignored while full
    ctrl(8'h10);
    count0 = 16'h0001;
    ctrl(8'h00);
    count0 = 16'h0002;
    ctrl(8'h00);
    rd_lit(2'b00, 8'h01, "latch_full_ignored");
    rd_lit(2'b00, 8'h02, "latch_released");

    // read and latch on counter2 in the same cycle
    ctrl(8'h90);
    count2 = 16'h00AA;
    ctrl(8'h80);
    count2 = 16'h1111;
    ctrl_data = 8'h80;
    ctrl_wr = 1'b1;
    rd_lit(2'b10, 8'hAA, "same_cycle_pre");
    ctrl_wr = 1'b0;
    count2 = 16'h2222;
    rd_lit(2'b10, 8'h11, "same_cycle_new");
    rd_lit(2'b10, 8'h22, "same_cycle_live");

    // control address and deselected read
    rd_lit(2'b11, 8'h00, "ctrl_addr_read");
    {A0, A1} = 2'b00;
    rd = 1'b1;
    CS = 1'b0;
    cyc();
    rd = 1'b0;
    @(negedge clk);
    check("cs_low_ignored", {15'h0, dout_valid}, 16'h0);

    // latch between LSB and MSB of the live count keeps the pointer
    ctrl(8'h30);
    count0 = 16'hBEEF;
    rd_lit(2'b00, 8'hEF, "mid_lsb");
    ctrl(8'h00);
    count0 = 16'h1234;
    rd_lit(2'b00, 8'hBE, "mid_latched_msb");
    rd_lit(2'b00, 8'h34, "mid_live_after");

    // reset mid-sequence
    ctrl(8'h30);
    count0 = 16'hBEEF;
    rd_lit(2'b00, 8'hEF, "pre_rst_lsb");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dout", {8'h0, dout}, 16'h0);
    check("async_rst_valid", {15'h0, dout_valid}, 16'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    rd_lit(2'b00, 8'hEF, "post_rst_lsb");
    rd_lit(2'b00, 8'hEF, "post_rst_lsb_only");

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rd        = ($urandom_range(0, 2) == 0);
      CS        = ($urandom_range(0, 3) != 0);
      A0        = 1'($urandom_range(0, 1));
      A1        = 1'($urandom_range(0, 1));
      ctrl_wr   = ($urandom_range(0, 4) == 0);
      ctrl_data = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) count0 = 16'($urandom);
      if ($urandom_range(0, 2) == 0) count1 = 16'($urandom);
      if ($urandom_range(0, 2) == 0) count2 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) status0 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) status1 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) status2 = 8'($urandom);
      if (i % 997 == 500) begin
        #3;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      cyc();
    end
    rd      = 1'b0;
    ctrl_wr = 1'b0;
    cyc();
    cyc();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
